// File: rtl/soc_bus_pkg.sv
// Shared types for the single-master bus fabric: FSM states, the {m_ready,m_err}
// response encoding and the region-index macro used by the address decoder.
`ifndef SOC_BUS_PKG_SV
`define SOC_BUS_PKG_SV

// Region index = top sel_w bits of a byte address.
`define SOC_BUS_REGION(addr, aw, sel_w) addr[(aw)-1 -: (sel_w)]

package soc_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2,
    ST_ERR    = 2'd3
  } state_e;

  // Bit 1 drives m_ready, bit 0 drives m_err.
  typedef enum logic [1:0] {
    RSP_NONE = 2'b00,
    RSP_OK   = 2'b10,
    RSP_ERR  = 2'b11
  } resp_e;

endpackage

`endif

// File: rtl/bus_region_decode.sv
// Combinational region decoder: turns a region index into a one-hot slave
// strobe and reports whether the index maps onto an existing slave.
module bus_region_decode
  import soc_bus_pkg::*;
#(
  parameter int N_SLV = 4,
  parameter int SEL_W = 2
) (
  input  logic [SEL_W-1:0] sel,
  output logic [N_SLV-1:0] onehot,
  output logic             mapped
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < N_SLV; i++) begin
      onehot[i] = (sel == SEL_W'(i));
    end
  end

  // Indices at or above N_SLV match no slave, so the strobe is all-zero.
  assign mapped = |onehot;

endmodule

// File: rtl/soc_bus_fabric.sv
// Single-master memory-mapped bus fabric: latches one request, strobes the
// decoded slave until it answers or times out, then returns a one-cycle completion.
module soc_bus_fabric
  import soc_bus_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int N_SLV   = 4,
  parameter int SEL_W   = 2,
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m_ce,
  input  logic                m_wr,
  input  logic [AW-1:0]       m_addr,
  input  logic [DW-1:0]       m_wdata,
  output logic [DW-1:0]       m_rdata,
  output logic                m_ready,
  output logic                m_err,
  output logic [N_SLV-1:0]    s_ce,
  output logic                s_wr,
  output logic [AW-1:0]       s_addr,
  output logic [DW-1:0]       s_wdata,
  input  logic [N_SLV*DW-1:0] s_rdata,
  input  logic [N_SLV-1:0]    s_ready
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  resp_e             resp_q, resp_d;
  logic [N_SLV-1:0]  s_ce_q, s_ce_d;
  logic              s_wr_q, s_wr_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic [DW-1:0]     rdata_q, rdata_d;
  logic [CW-1:0]     cnt_q, cnt_d, cnt_inc;

  logic [SEL_W-1:0]  req_sel;
  logic [N_SLV-1:0]  req_onehot;
  logic              req_mapped;
  logic              sel_ready;
  logic [DW-1:0]     sel_rdata;

  assign req_sel = `SOC_BUS_REGION(m_addr, AW, SEL_W);

  bus_region_decode #(
    .N_SLV (N_SLV),
    .SEL_W (SEL_W)
  ) u_decode (
    .sel    (req_sel),
    .onehot (req_onehot),
    .mapped (req_mapped)
  );

  // The registered strobe picks the answering slave, so other slaves' ready is ignored.
  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < N_SLV; i++) begin
      if (s_ce_q[i]) begin
        sel_ready |= s_ready[i];
        sel_rdata |= s_rdata[i*DW +: DW];
      end
    end
  end

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    resp_d  = RSP_NONE;
    s_ce_d  = s_ce_q;
    s_wr_d  = s_wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (m_ce) begin
          addr_d  = m_addr;
          wdata_d = m_wdata;
          if (req_mapped) begin
            s_ce_d  = req_onehot;
            s_wr_d  = m_wr;
            state_d = ST_ACCESS;
          end else begin
            rdata_d = '0;
            resp_d  = RSP_ERR;
            state_d = ST_ERR;
          end
        end
      end
      ST_ACCESS: begin
        // A ready on the final allowed cycle still wins over the timeout.
        if (sel_ready) begin
          if (!s_wr_q) begin
            rdata_d = sel_rdata;
          end
          s_ce_d  = '0;
          s_wr_d  = 1'b0;
          resp_d  = RSP_OK;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CW'(TIMEOUT)) begin
            s_ce_d  = '0;
            s_wr_d  = 1'b0;
            rdata_d = '0;
            resp_d  = RSP_ERR;
            state_d = ST_ERR;
          end
        end
      end
      ST_RESP, ST_ERR: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      resp_q  <= RSP_NONE;
      s_ce_q  <= '0;
      s_wr_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      resp_q  <= resp_d;
      s_ce_q  <= s_ce_d;
      s_wr_q  <= s_wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  assign m_ready = resp_q[1];
  assign m_err   = resp_q[0];
  assign m_rdata = rdata_q;
  assign s_ce    = s_ce_q;
  assign s_wr    = s_wr_q;
  assign s_addr  = addr_q;
  assign s_wdata = wdata_q;

endmodule

// File: tb/tb_soc_bus_fabric.sv
// Directed bench for soc_bus_fabric with three slave models that have
// programmable wait states, a never-ready mode and a stray-ready injector.
module tb_soc_bus_fabric;

  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int N_SLV   = 3;
  localparam int SEL_W   = 2;
  localparam int TIMEOUT = 4;

  logic                clk;
  logic                rst;
  logic                m_ce;
  logic                m_wr;
  logic [AW-1:0]       m_addr;
  logic [DW-1:0]       m_wdata;
  logic [DW-1:0]       m_rdata;
  logic                m_ready;
  logic                m_err;
  logic [N_SLV-1:0]    s_ce;
  logic                s_wr;
  logic [AW-1:0]       s_addr;
  logic [DW-1:0]       s_wdata;
  logic [N_SLV*DW-1:0] s_rdata;
  logic [N_SLV-1:0]    s_ready;

  logic [DW-1:0]       slv_rdata [N_SLV];
  logic [2:0]          wait_cfg  [N_SLV];
  logic [2:0]          scnt      [N_SLV];
  logic [N_SLV-1:0]    never;
  logic [N_SLV-1:0]    stray;
  logic [AW-1:0]       seen_addr;
  logic [DW-1:0]       seen_wdata;
  logic                seen_wr;

  logic [DW-1:0]       exp_q [$];
  int                  tests_run;
  int                  tests_failed;

  soc_bus_fabric #(
    .AW      (AW),
    .DW      (DW),
    .N_SLV   (N_SLV),
    .SEL_W   (SEL_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .m_ce    (m_ce),
    .m_wr    (m_wr),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_rdata (m_rdata),
    .m_ready (m_ready),
    .m_err   (m_err),
    .s_ce    (s_ce),
    .s_wr    (s_wr),
    .s_addr  (s_addr),
    .s_wdata (s_wdata),
    .s_rdata (s_rdata),
    .s_ready (s_ready)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave models: ready after wait_cfg cycles of strobe, unless never-ready.
  assign s_rdata = {slv_rdata[2], slv_rdata[1], slv_rdata[0]};

  always_comb begin
    for (int i = 0; i < N_SLV; i++) begin
      s_ready[i] = (s_ce[i] && !never[i] && (scnt[i] == wait_cfg[i])) || stray[i];
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < N_SLV; i++) begin
      if (!s_ce[i] || s_ready[i]) scnt[i] <= '0;
      else                        scnt[i] <= scnt[i] + 3'd1;
      if (s_ce[i] && s_ready[i]) begin
        seen_addr  <= s_addr;
        seen_wdata <= s_wdata;
        seen_wr    <= s_wr;
      end
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    m_ce    = 1'b1;
    m_wr    = wr;
    m_addr  = addr;
    m_wdata = wdata;
  endtask

  task automatic scramble_master();
    m_ce    = 1'b0;
    m_wr    = ~m_wr;
    m_addr  = $urandom_range(0, 32'h3fff_ffff);
    m_wdata = $urandom;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int comp_cnt;
  int comp_cyc [2];

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst     = 1'b1;
    m_ce    = 1'b0;
    m_wr    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    never   = '0;
    stray   = '0;
    for (int i = 0; i < N_SLV; i++) begin
      wait_cfg[i]  = 3'd0;
      slv_rdata[i] = '0;
      scnt[i]      = '0;
    end

    // Reset state
    step();
    step();
    chk("rst_s_ce",    64'(s_ce),    64'd0);
    chk("rst_s_wr",    64'(s_wr),    64'd0);
    chk("rst_m_ready", 64'(m_ready), 64'd0);
    chk("rst_m_err",   64'(m_err),   64'd0);
    chk("rst_m_rdata", 64'(m_rdata), 64'd0);
    chk("rst_s_addr",  64'(s_addr),  64'd0);
    chk("rst_s_wdata", 64'(s_wdata), 64'd0);
    rst = 1'b0;
    step();

    // 1: zero-wait read from slave0, master drops m_ce in cycle 1
    slv_rdata[0] = 32'hDEAD_BEEF;
    start(1'b0, 32'h0000_0010, 32'h0);
    step();
    chk("t1_s_ce_c1",   64'(s_ce),    64'b001);
    chk("t1_s_wr_c1",   64'(s_wr),    64'd0);
    chk("t1_s_addr_c1", 64'(s_addr),  64'h0000_0010);
    chk("t1_ready_c1",  64'(m_ready), 64'd0);
    scramble_master();
    step();
    chk("t1_ready_c2",  64'(m_ready), 64'd1);
    chk("t1_err_c2",    64'(m_err),   64'd0);
    chk("t1_rdata_c2",  64'(m_rdata), 64'hDEAD_BEEF);
    chk("t1_s_ce_c2",   64'(s_ce),    64'd0);
    step();
    chk("t1_ready_c3",  64'(m_ready), 64'd0);

    // 2: write to slave2 (last valid region) with 2 wait states
    wait_cfg[2] = 3'd2;
    start(1'b1, 32'h8000_0004, 32'h1234_5678);
    step();
    scramble_master();
    for (int c = 1; c <= 3; c++) begin
      chk($sformatf("t2_s_ce_c%0d", c),  64'(s_ce),    64'b100);
      chk($sformatf("t2_s_wr_c%0d", c),  64'(s_wr),    64'd1);
      chk($sformatf("t2_addr_c%0d", c),  64'(s_addr),  64'h8000_0004);
      chk($sformatf("t2_wdata_c%0d", c), 64'(s_wdata), 64'h1234_5678);
      chk($sformatf("t2_ready_c%0d", c), 64'(m_ready), 64'd0);
      step();
    end
    chk("t2_ready_c4",   64'(m_ready),    64'd1);
    chk("t2_err_c4",     64'(m_err),      64'd0);
    chk("t2_rdata_keep", 64'(m_rdata),    64'hDEAD_BEEF);
    chk("t2_seen_addr",  64'(seen_addr),  64'h8000_0004);
    chk("t2_seen_wdata", 64'(seen_wdata), 64'h1234_5678);
    chk("t2_seen_wr",    64'(seen_wr),    64'd1);
    wait_cfg[2] = 3'd0;
    step();

    // 3: unmapped region (sel=3)
    start(1'b0, 32'hC000_0000, 32'h0);
    step();
    scramble_master();
    chk("t3_s_ce_c1",  64'(s_ce),    64'd0);
    chk("t3_ready_c1", 64'(m_ready), 64'd1);
    chk("t3_err_c1",   64'(m_err),   64'd1);
    chk("t3_rdata_c1", 64'(m_rdata), 64'd0);
    step();
    chk("t3_ready_c2", 64'(m_ready), 64'd0);
    chk("t3_err_c2",   64'(m_err),   64'd0);

    // 4a: slave1 never ready, other slaves wave ready around
    never[1] = 1'b1;
    stray    = 3'b101;
    start(1'b0, 32'h4000_0008, 32'h0);
    step();
    scramble_master();
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("t4a_s_ce_c%0d", c),  64'(s_ce),    64'b010);
      chk($sformatf("t4a_ready_c%0d", c), 64'(m_ready), 64'd0);
      step();
    end
    chk("t4a_s_ce_c5",  64'(s_ce),    64'd0);
    chk("t4a_ready_c5", 64'(m_ready), 64'd1);
    chk("t4a_err_c5",   64'(m_err),   64'd1);
    chk("t4a_rdata_c5", 64'(m_rdata), 64'd0);
    stray    = '0;
    never[1] = 1'b0;
    step();
    chk("t4a_ready_c6", 64'(m_ready), 64'd0);

    // 4b: slave1 ready exactly on the 4th strobe cycle
    wait_cfg[1]  = 3'd3;
    slv_rdata[1] = 32'hA5A5_0001;
    start(1'b0, 32'h4000_000C, 32'h0);
    step();
    scramble_master();
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("t4b_s_ce_c%0d", c), 64'(s_ce), 64'b010);
      step();
    end
    chk("t4b_ready_c5", 64'(m_ready), 64'd1);
    chk("t4b_err_c5",   64'(m_err),   64'd0);
    chk("t4b_rdata_c5", 64'(m_rdata), 64'hA5A5_0001);
    wait_cfg[1] = 3'd0;
    step();

    // 5: m_ce held across two reads (slave0 then slave1)
    slv_rdata[0] = 32'h1111_0000;
    slv_rdata[1] = 32'h2222_0001;
    exp_q.push_back(32'h1111_0000);
    exp_q.push_back(32'h2222_0001);
    comp_cnt = 0;
    start(1'b0, 32'h0000_0020, 32'h0);
    for (int c = 1; c <= 8; c++) begin
      step();
      if (c == 1) m_addr = 32'h4000_0030;
      if (m_ready) begin
        if (comp_cnt < 2) comp_cyc[comp_cnt] = c;
        comp_cnt++;
        chk($sformatf("t5_err_c%0d", c), 64'(m_err), 64'd0);
        if (exp_q.size() > 0) chk($sformatf("t5_rdata_c%0d", c), 64'(m_rdata), 64'(exp_q.pop_front()));
        else chk($sformatf("t5_extra_c%0d", c), 64'(m_ready), 64'd0);
      end
      if (c == 4) m_ce = 1'b0;
    end
    chk("t5_completions", 64'(comp_cnt),    64'd2);
    chk("t5_first_cyc",   64'(comp_cyc[0]), 64'd2);
    chk("t5_second_cyc",  64'(comp_cyc[1]), 64'd5);
    chk("t5_queue_empty", 64'(exp_q.size()), 64'd0);
    exp_q.delete();

    // 6: async reset during ACCESS, then a fresh read
    never[2] = 1'b1;
    start(1'b0, 32'h8000_0040, 32'h0);
    step();
    scramble_master();
    chk("t6_s_ce_c1", 64'(s_ce), 64'b100);
    step();
    #2;
    rst = 1'b1;
    #1;
    chk("t6_s_ce_rst",  64'(s_ce),    64'd0);
    chk("t6_ready_rst", 64'(m_ready), 64'd0);
    chk("t6_err_rst",   64'(m_err),   64'd0);
    step();
    rst      = 1'b0;
    never[2] = 1'b0;
    step();
    chk("t6_s_ce_post",  64'(s_ce),    64'd0);
    chk("t6_ready_post", 64'(m_ready), 64'd0);
    slv_rdata[0] = 32'h0BAD_F00D;
    start(1'b0, 32'h0000_0100, 32'h0);
    step();
    scramble_master();
    chk("t6_new_s_ce_c1", 64'(s_ce), 64'b001);
    step();
    chk("t6_new_ready_c2", 64'(m_ready), 64'd1);
    chk("t6_new_err_c2",   64'(m_err),   64'd0);
    chk("t6_new_rdata_c2", 64'(m_rdata), 64'h0BAD_F00D);
    step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
